// File: rtl/decode_issue_unit.sv
// Decode stage with integrated ID/EX register: field decode, register file with optional
// write-back bypass, load-use bubble insertion, branch flush and illegal-opcode tagging.
module decode_issue_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 12,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TOTAL_REGS     = 32,
  parameter bit WB_BYPASS      = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      if_valid,
  input  logic [DATA_WIDTH-1:0]     instruction,
  input  logic [ADDR_WIDTH-1:0]     pc_current,
  input  logic [ADDR_WIDTH-1:0]     pc_plus_4,
  input  logic                      flush,
  input  logic                      WB_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] WB_write_addr,
  input  logic [DATA_WIDTH-1:0]     WB_write_data,
  output logic                      hazard_stall,
  output logic                      ex_valid,
  output logic                      alu_src,
  output logic                      branch,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic                      mem_to_reg,
  output logic                      reg_write,
  output logic [1:0]                alu_op,
  output logic [DATA_WIDTH-1:0]     read_data_1,
  output logic [DATA_WIDTH-1:0]     read_data_2,
  output logic [DATA_WIDTH-1:0]     immediate,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [6:0]                funct7,
  output logic [2:0]                funct3,
  output logic [ADDR_WIDTH-1:0]     pc_current_out,
  output logic [ADDR_WIDTH-1:0]     pc_plus_4_out,
  output logic                      illegal_instr
);

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  typedef struct packed {
    logic                      valid;
    ctrl_t                     ctrl;
    logic                      illegal;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     imm;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [6:0]                funct7;
    logic [2:0]                funct3;
    logic [ADDR_WIDTH-1:0]     pc;
    logic [ADDR_WIDTH-1:0]     pc4;
  } idex_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;

  logic [DATA_WIDTH-1:0]     rf_q [TOTAL_REGS];
  idex_t                     idex_q, idex_d;
  ctrl_t                     ctrl;
  logic [DATA_WIDTH-1:0]     imm;
  logic                      uses_rs1, uses_rs2, illegal;
  logic [REG_ADDR_WIDTH-1:0] rs1_dec, rs2_dec, rd_dec;
  logic [1:0][REG_ADDR_WIDTH-1:0] raddr;
  logic [1:0][DATA_WIDTH-1:0]     rdata;

  assign rs1_dec = REG_ADDR_WIDTH'(instruction[19:15]);
  assign rs2_dec = REG_ADDR_WIDTH'(instruction[24:20]);
  assign rd_dec  = REG_ADDR_WIDTH'(instruction[11:7]);
  assign raddr   = {rs2_dec, rs1_dec};

  always_comb begin
    ctrl     = '0;
    imm      = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    unique case (instruction[6:0])
      OP_R:  begin ctrl = 8'b0100_0001; uses_rs2 = 1'b1; end
      OP_I:  begin ctrl = 8'b1100_0001; imm = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:20]}; end
      OP_LD: begin ctrl = 8'b1000_1011; imm = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:20]}; end
      OP_ST: begin
        ctrl = 8'b1000_0100; uses_rs2 = 1'b1;
        imm  = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OP_BR: begin
        ctrl = 8'b0011_0000; uses_rs2 = 1'b1;
        imm  = {{(DATA_WIDTH-13){instruction[31]}}, instruction[31], instruction[7],
                instruction[30:25], instruction[11:8], 1'b0};
      end
      default: begin uses_rs1 = 1'b0; illegal = 1'b1; end
    endcase
  end

  // Reads of x0 or addresses beyond the file depth return zero.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < 2; p++) begin
      if (raddr[p] != '0 && int'(raddr[p]) < TOTAL_REGS) begin
        if (WB_BYPASS && WB_reg_write && raddr[p] == WB_write_addr) rdata[p] = WB_write_data;
        else                                                      rdata[p] = rf_q[raddr[p]];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TOTAL_REGS; i++) rf_q[i] <= '0;
    end else if (WB_reg_write && WB_write_addr != '0 && int'(WB_write_addr) < TOTAL_REGS) begin
      rf_q[WB_write_addr] <= WB_write_data;
    end
  end

  // EX-slot state is all zero in reset, so the stall is naturally low there.
  assign hazard_stall = if_valid & ~flush & idex_q.valid & idex_q.ctrl.mem_read &
                        (idex_q.rd != '0) &
                        (((idex_q.rd == rs1_dec) & uses_rs1) | ((idex_q.rd == rs2_dec) & uses_rs2));

  always_comb begin
    idex_d = '0;
    if (!flush && !hazard_stall && if_valid) begin
      idex_d.valid   = 1'b1;
      idex_d.ctrl    = ctrl;
      idex_d.illegal = illegal;
      idex_d.rd1     = rdata[0];
      idex_d.rd2     = rdata[1];
      idex_d.imm     = imm;
      idex_d.rs1     = rs1_dec;
      idex_d.rs2     = rs2_dec;
      idex_d.rd      = rd_dec;
      idex_d.funct7  = instruction[31:25];
      idex_d.funct3  = instruction[14:12];
      idex_d.pc      = pc_current;
      idex_d.pc4     = pc_plus_4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign ex_valid       = idex_q.valid;
  assign alu_src        = idex_q.ctrl.alu_src;
  assign alu_op         = idex_q.ctrl.alu_op;
  assign branch         = idex_q.ctrl.branch;
  assign mem_read       = idex_q.ctrl.mem_read;
  assign mem_write      = idex_q.ctrl.mem_write;
  assign mem_to_reg     = idex_q.ctrl.mem_to_reg;
  assign reg_write      = idex_q.ctrl.reg_write;
  assign illegal_instr  = idex_q.illegal;
  assign read_data_1    = idex_q.rd1;
  assign read_data_2    = idex_q.rd2;
  assign immediate      = idex_q.imm;
  assign rs1            = idex_q.rs1;
  assign rs2            = idex_q.rs2;
  assign rd             = idex_q.rd;
  assign funct7         = idex_q.funct7;
  assign funct3         = idex_q.funct3;
  assign pc_current_out = idex_q.pc;
  assign pc_plus_4_out  = idex_q.pc4;

endmodule

// File: tb/tb_decode_issue_unit.sv
// Directed bench for decode_issue_unit: a bypassing instance and a non-bypassing one share stimulus.
module tb_decode_issue_unit;
  localparam int DW = 32, AW = 12, RW = 5;

  logic gclk = 1'b0, grst_n;
  logic if_valid, flush, wb_we;
  logic [DW-1:0] instr, wb_data;
  logic [AW-1:0] pc, pc4;
  logic [RW-1:0] wb_addr;

  logic stall, exv, asrc, br, mrd, mwr, m2r, rwr, ill;
  logic [1:0] aop;
  logic [DW-1:0] rd1, rd2, imm;
  logic [RW-1:0] o_rs1, o_rs2, o_rd;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [AW-1:0] pco, pc4o;

  logic n_stall, n_exv, n_asrc, n_br, n_mrd, n_mwr, n_m2r, n_rwr, n_ill;
  logic [1:0] n_aop;
  logic [DW-1:0] n_rd1, n_rd2, n_imm;
  logic [RW-1:0] n_rs1, n_rs2, n_rd;
  logic [6:0] n_f7;
  logic [2:0] n_f3;
  logic [AW-1:0] n_pco, n_pc4o;

  int checks = 0, errors = 0;

  always #5 gclk = ~gclk;

  decode_issue_unit #(.WB_BYPASS(1'b1)) dut (
    .clk(gclk), .reset(grst_n), .if_valid(if_valid), .instruction(instr),
    .pc_current(pc), .pc_plus_4(pc4), .flush(flush), .WB_reg_write(wb_we),
    .WB_write_addr(wb_addr), .WB_write_data(wb_data), .hazard_stall(stall), .ex_valid(exv),
    .alu_src(asrc), .branch(br), .mem_read(mrd), .mem_write(mwr), .mem_to_reg(m2r),
    .reg_write(rwr), .alu_op(aop), .read_data_1(rd1), .read_data_2(rd2), .immediate(imm),
    .rs1(o_rs1), .rs2(o_rs2), .rd(o_rd), .funct7(f7), .funct3(f3),
    .pc_current_out(pco), .pc_plus_4_out(pc4o), .illegal_instr(ill));

  decode_issue_unit #(.WB_BYPASS(1'b0)) dut_nb (
    .clk(gclk), .reset(grst_n), .if_valid(if_valid), .instruction(instr),
    .pc_current(pc), .pc_plus_4(pc4), .flush(flush), .WB_reg_write(wb_we),
    .WB_write_addr(wb_addr), .WB_write_data(wb_data), .hazard_stall(n_stall), .ex_valid(n_exv),
    .alu_src(n_asrc), .branch(n_br), .mem_read(n_mrd), .mem_write(n_mwr), .mem_to_reg(n_m2r),
    .reg_write(n_rwr), .alu_op(n_aop), .read_data_1(n_rd1), .read_data_2(n_rd2), .immediate(n_imm),
    .rs1(n_rs1), .rs2(n_rs2), .rd(n_rd), .funct7(n_f7), .funct3(n_f3),
    .pc_current_out(n_pco), .pc_plus_4_out(n_pc4o), .illegal_instr(n_ill));

  // {alu_src, alu_op, branch, mem_read, mem_write, mem_to_reg, reg_write}
  wire [7:0] ctl = {asrc, aop, br, mrd, mwr, m2r, rwr};
  wire [158:0] all_regs = {exv, ctl, ill, rd1, rd2, imm, o_rs1, o_rs2, o_rd, f7, f3, pco, pc4o};

  task automatic tick;
    @(posedge gclk); #1;
  endtask

  task automatic wb_write(input logic [RW-1:0] a, input logic [DW-1:0] d);
    @(negedge gclk);
    if_valid = 1'b0; wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset;
    grst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; wb_we = 1'b0;
    instr = '0; pc = '0; pc4 = '0; wb_addr = '0; wb_data = '0;
    repeat (3) tick();
    checks++; if (all_regs !== '0) begin errors++; $display("FAIL reset_regs got %h exp 0", all_regs); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    @(negedge gclk); grst_n = 1'b1;
    for (int i = 1; i < 32; i++) begin
      @(negedge gclk);
      if_valid = 1'b1; instr = {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'b0110011};
      tick();
      checks++;
      if (exv !== 1'b1 || rd1 !== '0 || rd2 !== '0) begin
        errors++; $display("FAIL reset_rf x%0d got v=%b %h %h exp v=1 0 0", i, exv, rd1, rd2);
      end
    end
    @(negedge gclk); if_valid = 1'b0;
  endtask

  task automatic test_decode;
    wb_write(5'd1, 32'd10);
    wb_write(5'd2, 32'h22);
    @(negedge gclk);
    if_valid = 1'b1; instr = 32'hFFC08293; pc = 12'h100; pc4 = 12'h104;
    tick();
    checks++; if (exv !== 1'b1 || ctl !== 8'b1100_0001) begin errors++; $display("FAIL addi_ctl got v=%b %b exp v=1 11000001", exv, ctl); end
    checks++; if (o_rd !== 5'd5 || o_rs1 !== 5'd1 || rd1 !== 32'd10) begin errors++; $display("FAIL addi_regs got rd=%0d rs1=%0d d1=%h exp 5 1 a", o_rd, o_rs1, rd1); end
    checks++; if (imm !== 32'hFFFFFFFC || ill !== 1'b0) begin errors++; $display("FAIL addi_imm got %h ill=%b exp fffffffc 0", imm, ill); end
    checks++; if (pco !== 12'h100 || pc4o !== 12'h104) begin errors++; $display("FAIL addi_pc got %h %h exp 100 104", pco, pc4o); end
    @(negedge gclk); instr = 32'hFE20AC23; // sw x2,-8(x1)
    tick();
    checks++; if (ctl !== 8'b1000_0100 || imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL sw got ctl=%b imm=%h exp 10000100 fffffff8", ctl, imm); end
    checks++; if (rd1 !== 32'd10 || rd2 !== 32'h22 || f3 !== 3'd2) begin errors++; $display("FAIL sw_data got %h %h f3=%0d exp a 22 2", rd1, rd2, f3); end
    @(negedge gclk); instr = 32'hFE2088E3; // beq x1,x2,-16
    tick();
    checks++; if (ctl !== 8'b0011_0000 || imm !== 32'hFFFFFFF0) begin errors++; $display("FAIL beq got ctl=%b imm=%h exp 00110000 fffffff0", ctl, imm); end
    checks++; if (f7 !== 7'h7F || o_rs2 !== 5'd2) begin errors++; $display("FAIL beq_fields got f7=%h rs2=%0d exp 7f 2", f7, o_rs2); end
    @(negedge gclk); instr = 32'h0000A103; // lw x2,0(x1)
    tick();
    checks++; if (ctl !== 8'b1000_1011 || imm !== '0) begin errors++; $display("FAIL lw got ctl=%b imm=%h exp 10001011 0", ctl, imm); end
    @(negedge gclk); if_valid = 1'b0;
    tick();
    checks++; if (exv !== 1'b0 || ctl !== '0) begin errors++; $display("FAIL idle_bubble got v=%b ctl=%b exp 0 0", exv, ctl); end
  endtask

  task automatic test_load_use;
    @(negedge gclk); if_valid = 1'b1; instr = 32'h0000A103; // lw x2,0(x1)
    tick();
    checks++; if (exv !== 1'b1 || mrd !== 1'b1 || o_rd !== 5'd2) begin errors++; $display("FAIL lu_load got v=%b mr=%b rd=%0d exp 1 1 2", exv, mrd, o_rd); end
    @(negedge gclk); instr = 32'h002101B3; // add x3,x2,x2
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", stall); end
    tick();
    checks++; if (exv !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%b stall=%b exp 0 0", exv, stall); end
    @(negedge gclk); wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    tick();
    checks++; if (exv !== 1'b1 || o_rd !== 5'd3 || rd1 !== 32'h55 || rd2 !== 32'h55) begin errors++; $display("FAIL lu_issue got v=%b rd=%0d %h %h exp 1 3 55 55", exv, o_rd, rd1, rd2); end
    checks++; if (n_rd1 !== 32'h22) begin errors++; $display("FAIL lu_nobypass got %h exp 22", n_rd1); end
    @(negedge gclk); wb_we = 1'b0; if_valid = 1'b0;
  endtask

  task automatic test_bypass;
    wb_write(5'd7, 32'h11111111);
    @(negedge gclk);
    if_valid = 1'b1; instr = 32'h00038433; // add x8,x7,x0
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    tick();
    checks++; if (rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_on got %h exp deadbeef", rd1); end
    checks++; if (n_rd1 !== 32'h11111111) begin errors++; $display("FAIL byp_off got %h exp 11111111", n_rd1); end
    @(negedge gclk); wb_we = 1'b0;
    tick();
    checks++; if (n_rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_commit got %h exp deadbeef", n_rd1); end
    @(negedge gclk); instr = 32'h00000433; // add x8,x0,x0
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    tick();
    checks++; if (rd1 !== '0 || n_rd1 !== '0) begin errors++; $display("FAIL x0_byp got %h %h exp 0 0", rd1, n_rd1); end
    @(negedge gclk); wb_we = 1'b0;
    tick();
    checks++; if (rd1 !== '0 || rd2 !== '0) begin errors++; $display("FAIL x0_write got %h %h exp 0 0", rd1, rd2); end
    @(negedge gclk); if_valid = 1'b0;
  endtask

  task automatic test_flush;
    @(negedge gclk); if_valid = 1'b1; instr = 32'h0000A103;
    tick();
    @(negedge gclk); instr = 32'h002101B3; flush = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", stall); end
    tick();
    checks++; if (exv !== 1'b0 || ctl !== '0) begin errors++; $display("FAIL flush_bubble got v=%b ctl=%b exp 0 0", exv, ctl); end
    @(negedge gclk); flush = 1'b0; if_valid = 1'b0;
  endtask

  task automatic test_illegal;
    @(negedge gclk); if_valid = 1'b1; instr = 32'h0000007F; pc = 12'h2A0;
    tick();
    checks++; if (exv !== 1'b1 || ill !== 1'b1 || ctl !== '0 || imm !== '0) begin errors++; $display("FAIL illegal got v=%b ill=%b ctl=%b imm=%h exp 1 1 0 0", exv, ill, ctl, imm); end
    checks++; if (pco !== 12'h2A0) begin errors++; $display("FAIL illegal_pc got %h exp 2a0", pco); end
    #2 grst_n = 1'b0;
    #1;
    checks++; if (all_regs !== '0 || stall !== 1'b0) begin errors++; $display("FAIL async_reset got %h stall=%b exp 0 0", all_regs, stall); end
    @(negedge gclk); grst_n = 1'b1; if_valid = 1'b0;
    tick();
    checks++; if (exv !== 1'b0) begin errors++; $display("FAIL post_reset got v=%b exp 0", exv); end
    @(negedge gclk); if_valid = 1'b1; instr = 32'h00038433; // x7 cleared by reset
    tick();
    checks++; if (exv !== 1'b1 || rd1 !== '0) begin errors++; $display("FAIL post_reset_rf got v=%b %h exp 1 0", exv, rd1); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_bypass();
    test_flush();
    test_illegal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
